// File: rtl/trace_column_writer.sv
// trace_column_writer: draws one oscilloscope-style column per sample set into a BRAM back buffer.
// Define TRACE_LINE_FILL_EN to join each channel's trace to its previous column with a vertical line.
module trace_column_writer #(
  parameter int VAL_RES = 16,
  parameter int NUM_CH = 2,
  parameter int LOG2_WIDTH = 10,
  parameter int LOG2_HEIGHT = 9,
  parameter int WIDTH = 1024,
  parameter int HEIGHT = 512,
  parameter int ADDR_WIDTH = LOG2_WIDTH + LOG2_HEIGHT
) (
  input  logic clkWR,
  input  logic rst,
  input  logic s_valid,
  output logic s_ready,
  input  logic [NUM_CH*VAL_RES-1:0] s_val,
  output logic wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0] wr_data,
  output logic wr_buf,
  output logic frame_done
);
  typedef enum logic [2:0] {IDLE, CLEAN, CALC, DRAW, NEXT} state_t;
  localparam int PW = VAL_RES + LOG2_HEIGHT;
  localparam logic [LOG2_HEIGHT-1:0] ROW_MAX = LOG2_HEIGHT'(HEIGHT - 1);
  localparam logic [LOG2_WIDTH-1:0] COL_MAX = LOG2_WIDTH'(WIDTH - 1);
  localparam logic [1:0] CH_MAX = 2'(NUM_CH - 1);
  state_t state, state_nx;
  logic [NUM_CH*VAL_RES-1:0] val;
  logic [LOG2_WIDTH-1:0] x;
  logic [1:0] c;
  logic [LOG2_HEIGHT-1:0] row, hi, row_c, lo_c, hi_c;
  logic [VAL_RES-1:0] val_c;
  assign val_c = val[c*VAL_RES +: VAL_RES];
  // full-width product so the scale is exact before dropping the fraction bits
  assign row_c = ROW_MAX - LOG2_HEIGHT'((PW'(val_c) * PW'(HEIGHT)) >> VAL_RES);
`ifdef TRACE_LINE_FILL_EN
  logic [LOG2_HEIGHT-1:0] rc [4];
  logic [LOG2_HEIGHT-1:0] prev [4];
  logic [LOG2_HEIGHT-1:0] prev_c;
  // the first column of a frame has no predecessor, so it draws a single point
  assign prev_c = (x == '0) ? row_c : prev[c];
  assign lo_c = (prev_c < row_c) ? prev_c : row_c;
  assign hi_c = (prev_c < row_c) ? row_c : prev_c;
  always_ff @(posedge clkWR) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) prev[i] <= ROW_MAX;
    end else begin
      if (state == CALC) rc[c] <= row_c;
      if (state == NEXT) prev <= rc;
    end
  end
`else
  assign lo_c = row_c;
  assign hi_c = row_c;
`endif
  always_ff @(posedge clkWR) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = s_valid ? CLEAN : IDLE;
      CLEAN: state_nx = (row == ROW_MAX) ? CALC : CLEAN;
      CALC: state_nx = DRAW;
      DRAW: state_nx = (row != hi) ? DRAW : (c == CH_MAX) ? NEXT : CALC;
      NEXT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    s_ready = state == IDLE;
    wr_we = state == CLEAN || state == DRAW;
    wr_addr = wr_we ? ADDR_WIDTH'({row, x}) : '0;
    wr_data = (state == DRAW) ? c + 2'd1 : 2'd0;
    frame_done = state == NEXT && x == COL_MAX;
  end
  always_ff @(posedge clkWR) begin
    if (rst) begin
      x <= '0;
      c <= '0;
      row <= '0;
      hi <= '0;
      val <= '0;
      wr_buf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          val <= s_val;
          row <= '0;
          c <= '0;
        end
        CLEAN: row <= row + LOG2_HEIGHT'(1);
        CALC: begin
          row <= lo_c;
          hi <= hi_c;
        end
        DRAW: if (row == hi) c <= c + 2'd1;
              else row <= row + LOG2_HEIGHT'(1);
        NEXT: begin
          x <= (x == COL_MAX) ? '0 : x + LOG2_WIDTH'(1);
          wr_buf <= wr_buf ^ (x == COL_MAX);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_trace_column_writer.sv
// tb_trace_column_writer: randomized columns checked cycle by cycle against a per-column write-list model.
module tb_trace_column_writer;
  localparam int VR = 16, NC = 2, LW = 2, LH = 2, W = 4, H = 4;
  logic clkWR = 1'b0, rst = 1'b1, s_valid = 1'b0;
  logic [NC*VR-1:0] s_val = '0;
  logic s_ready, wr_we, wr_buf, frame_done;
  logic [LW+LH-1:0] wr_addr;
  logic [1:0] wr_data;
  int checks = 0, passed = 0;
  logic [9:0] q[$];
  int mx, cols, draws;
  int mprev[NC];
  logic mbuf;
  bit reset_armed;
  logic [NC*VR-1:0] dir[4];

  trace_column_writer #(.VAL_RES(VR), .NUM_CH(NC), .LOG2_WIDTH(LW), .LOG2_HEIGHT(LH),
                        .WIDTH(W), .HEIGHT(H)) dut (
    .clkWR(clkWR), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_val(s_val),
    .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_buf(wr_buf),
    .frame_done(frame_done));

  always #5 clkWR = ~clkWR;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // expected cycle word: {s_ready, frame_done, wr_buf, wr_we, wr_data, wr_addr}
  function automatic logic [9:0] ent(input logic fd, input logic we, input logic [1:0] d,
                                     input int row, input int col);
    logic [3:0] a;
    a = we ? {2'(row), 2'(col)} : 4'd0;
    return {1'b0, fd, mbuf, we, d, a};
  endfunction

  task automatic model_reset();
    q.delete();
    mx = 0;
    mbuf = 1'b0;
    for (int i = 0; i < NC; i++) mprev[i] = H - 1;
  endtask

  task automatic push_col(input logic [NC*VR-1:0] v);
    int r[NC];
    int lo, hi;
    for (int y = 0; y < H; y++) q.push_back(ent(1'b0, 1'b1, 2'd0, y, mx));
    for (int c = 0; c < NC; c++) begin
      r[c] = H - 1 - ((int'(v[c*VR +: VR]) * H) >> VR);
      q.push_back(ent(1'b0, 1'b0, 2'd0, 0, 0));
`ifdef TRACE_LINE_FILL_EN
      begin
        int p;
        p = (mx == 0) ? r[c] : mprev[c];
        lo = (p < r[c]) ? p : r[c];
        hi = (p < r[c]) ? r[c] : p;
      end
`else
      lo = r[c];
      hi = r[c];
`endif
      for (int y = lo; y <= hi; y++) q.push_back(ent(1'b0, 1'b1, 2'(c + 1), y, mx));
    end
    q.push_back(ent(mx == W - 1, 1'b0, 2'd0, 0, 0));
    for (int c = 0; c < NC; c++) mprev[c] = r[c];
    if (mx == W - 1) begin
      mx = 0;
      mbuf = ~mbuf;
    end else mx++;
  endtask

  initial begin
    logic [9:0] e, obs;
    dir[0] = {16'h8000, 16'hFFFF};
    dir[1] = {16'h8000, 16'h0000};
    dir[2] = {16'h8000, 16'h8000};
    dir[3] = {16'h0000, 16'h4000};
    model_reset();
    cols = 0;
    draws = 0;
    reset_armed = 0;
    repeat (2) @(posedge clkWR);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clkWR);
      obs = {s_ready, frame_done, wr_buf, wr_we, wr_data, wr_addr};
      e = (q.size() != 0) ? q.pop_front() : {1'b1, 1'b0, mbuf, 7'd0};
      check((cyc == 0) ? "reset" : $sformatf("col%0d_cyc%0d", cols, cyc), {22'd0, obs}, {22'd0, e});
      rst = 1'b0;
      if (e[6] && e[5:4] != 2'd0) draws++;
      if (reset_armed && draws == 2 && e[6] && e[5:4] != 2'd0) begin
        rst = 1'b1;
        s_valid = 1'b0;
        reset_armed = 0;
        model_reset();
      end else if (e[9]) begin
        if (cols < 4 || $urandom_range(0, 2) != 0) begin
          s_val = (cols < 4) ? dir[cols] : NC*VR'($urandom);
          s_valid = 1'b1;
          push_col(s_val);
          cols++;
          draws = 0;
          if (cols == 30) reset_armed = 1;
        end else s_valid = 1'b0;
      end else begin
        s_valid = (cols <= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        s_val = NC*VR'($urandom);
      end
    end
    check("columns_done", 32'(cols >= 40), 32'd1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
